// File: rtl/div_rest_qs_param.sv
// Multi-cycle restoring divider (signed/unsigned) with leading-zero quick start.
// Divide-by-zero, signed overflow and |a|<|b| resolve in the sampling cycle without iterating.
module div_rest_qs_param #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstLow,
    input  logic             start_in,
    input  logic             signed_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] r_out,
    output logic             busy,
    output logic             done
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PREP, LOOP, FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rq_q, rq_d;
    logic [WIDTH-1:0] rr_q, rr_d;
    logic [WIDTH-1:0] magb_q, magb_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [CW-1:0]    lz;
    logic [WIDTH:0]   res;

    always_ff @(posedge clk or negedge rstLow) begin
        if (!rstLow) begin
            state_q <= IDLE;
            rq_q    <= '0;
            rr_q    <= '0;
            magb_q  <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rq_q    <= rq_d;
            rr_q    <= rr_d;
            magb_q  <= magb_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rq_d    = rq_q;
        rr_d    = rr_q;
        magb_d  = magb_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        sa    = signed_in & a_in[WIDTH-1];
        sb    = signed_in & b_in[WIDTH-1];
        mag_a = sa ? -a_in : a_in;
        mag_b = sb ? -b_in : b_in;

        // |a| is parked in rq_q during PREP; last hit is the highest set bit
        lz = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (rq_q[i]) lz = CW'(WIDTH - 1 - i);
        end

        res = {rr_q, rq_q[WIDTH-1]} - {1'b0, magb_q};

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    if (b_in == '0) begin
                        q_d    = '1;
                        r_d    = a_in;
                        done_d = 1'b1;
                    end else if (signed_in && a_in == MOST_NEG && b_in == '1) begin
                        q_d    = a_in;
                        r_d    = '0;
                        done_d = 1'b1;
                    end else if (mag_a < mag_b) begin
                        q_d    = '0;
                        r_d    = a_in;
                        done_d = 1'b1;
                    end else begin
                        rq_d    = mag_a;
                        magb_d  = mag_b;
                        qneg_d  = sa ^ sb;
                        rneg_d  = sa;
                        busy_d  = 1'b1;
                        state_d = PREP;
                    end
                end
            end
            PREP: begin
                rq_d    = rq_q << lz;
                rr_d    = '0;
                cnt_d   = lz;
                state_d = LOOP;
            end
            LOOP: begin
                rq_d  = {rq_q[WIDTH-2:0], ~res[WIDTH]};
                rr_d  = res[WIDTH] ? {rr_q[WIDTH-2:0], rq_q[WIDTH-1]} : res[WIDTH-1:0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                q_d     = qneg_q ? -rq_q : rq_q;
                r_d     = (rneg_q && rr_q != '0) ? -rr_q : rr_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign q_out = q_q;
    assign r_out = r_q;
    assign busy  = busy_q;
    assign done  = done_q;
endmodule
